// File: rtl/nubus_master_fsm.sv
// nubus_master_fsm
//   NuBus master sequencer placed directly in front of the bus driver. It takes
//   one card-side request at a time and walks it through arbitration, address,
//   data and (for locked sequences) attention phases, emitting the active-low
//   phase strobes the driver decodes.
//
// Ports
//   nub_clk, nub_reset         clock, synchronous active-high reset
//   cpu_valid/addr/wdata/write/tm/lock
//                              request from the card side, stable until cpu_done
//   cpu_done                   one-clock completion pulse (ACK or timeout)
//   cpu_rdata, cpu_status      read data / slave status captured at completion
//   arb_win                    arbitration comparator result (used in ARB)
//   nub_startn, nub_ackn       sampled START* / ACK*
//   nub_tm1n, nub_tm0n         sampled TM1* / TM0* (slave response status at ACK)
//   nub_ad_i                   sampled AD bus
//   nub_ad_o, nub_ad_oe        AD value and output enable
//   mst_*n                     phase strobes to the driver (active low)
//   mst_timeout                one-clock timeout pulse to the driver
//
// Every output is a register loaded from the decode of the *next* state, so
// the strobes line up with the state they describe and only move on transitions.
module nubus_master_fsm #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        nub_clk,
  input  logic        nub_reset,
  input  logic        cpu_valid,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic        cpu_write,
  input  logic [1:0]  cpu_tm,
  input  logic        cpu_lock,
  output logic        cpu_done,
  output logic [31:0] cpu_rdata,
  output logic [1:0]  cpu_status,
  input  logic        arb_win,
  input  logic        nub_startn,
  input  logic        nub_ackn,
  input  logic        nub_tm1n,
  input  logic        nub_tm0n,
  input  logic [31:0] nub_ad_i,
  output logic [31:0] nub_ad_o,
  output logic        nub_ad_oe,
  output logic        mst_arbcyn,
  output logic        mst_adrcyn,
  output logic        mst_dtacyn,
  output logic        mst_ownern,
  output logic        mst_lockedn,
  output logic        mst_tm1n,
  output logic        mst_tm0n,
  output logic        mst_timeout
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARB,
    ST_ADDR,
    ST_DATA,
    ST_LOCKHOLD,
    ST_ATTN
  } state_t;

  // Last counter value before a forced timeout (counter is 0 in the first DATA clock).
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

  // Strobe vector order: {arbcyn, adrcyn, dtacyn, ownern, lockedn, tm1n, tm0n}
  localparam logic [6:0] STB_IDLE = 7'b111_1111;
  localparam int         OWN_BIT  = 3;

  state_t      state_reg, state_next;
  logic [6:0]  strobe_reg, strobe_next;
  logic        lock_reg, lock_next;
  logic        write_reg, write_next;
  logic [7:0]  cnt_reg, cnt_next;
  logic        bus_busy_reg, bus_busy_next;
  logic        done_reg, done_next;
  logic        tmo_reg, tmo_next;
  logic [31:0] rdata_reg, rdata_next;
  logic [1:0]  status_reg, status_next;
  logic        ad_oe_reg, ad_oe_next;
  logic [31:0] ad_o_reg, ad_o_next;
  logic        ack_hit, tmo_hit;

  always_ff @(posedge nub_clk) begin
    if (nub_reset) begin
      state_reg    <= ST_IDLE;
      strobe_reg   <= STB_IDLE;
      lock_reg     <= 1'b0;
      write_reg    <= 1'b0;
      cnt_reg      <= '0;
      bus_busy_reg <= 1'b0;
      done_reg     <= 1'b0;
      tmo_reg      <= 1'b0;
      rdata_reg    <= '0;
      status_reg   <= '0;
      ad_oe_reg    <= 1'b0;
      ad_o_reg     <= '0;
    end else begin
      state_reg    <= state_next;
      strobe_reg   <= strobe_next;
      lock_reg     <= lock_next;
      write_reg    <= write_next;
      cnt_reg      <= cnt_next;
      bus_busy_reg <= bus_busy_next;
      done_reg     <= done_next;
      tmo_reg      <= tmo_next;
      rdata_reg    <= rdata_next;
      status_reg   <= status_next;
      ad_oe_reg    <= ad_oe_next;
      ad_o_reg     <= ad_o_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    lock_next     = lock_reg;
    write_next    = write_reg;
    cnt_next      = cnt_reg;
    bus_busy_next = bus_busy_reg;
    done_next     = 1'b0;
    tmo_next      = 1'b0;
    rdata_next    = rdata_reg;
    status_next   = status_reg;
    strobe_next   = STB_IDLE;
    ad_oe_next    = 1'b0;
    ad_o_next     = '0;

    ack_hit = (state_reg == ST_DATA) && !nub_ackn;
    // ACK takes priority over a timeout landing on the same clock.
    tmo_hit = (state_reg == ST_DATA) && nub_ackn && (cnt_reg == TMO_LAST);

    // Foreign transaction tracking. START+ACK together is an attention cycle
    // and leaves the tracker alone.
    if (!nub_ackn && nub_startn)
      bus_busy_next = 1'b0;
    else if (!nub_startn && nub_ackn && strobe_reg[OWN_BIT])
      bus_busy_next = 1'b1;

    case (state_reg)
      // done_reg high means cpu_valid may still be the request just completed.
      ST_IDLE:     if (cpu_valid && !done_reg) state_next = ST_ARB;
      ST_ARB:      if (arb_win && !bus_busy_reg && nub_startn) state_next = ST_ADDR;
      ST_ADDR:     state_next = ST_DATA;
      ST_DATA: begin
        if (ack_hit)      state_next = lock_reg ? ST_LOCKHOLD : ST_IDLE;
        else if (tmo_hit) state_next = lock_reg ? ST_ATTN : ST_IDLE;
      end
      ST_LOCKHOLD: begin
        if (!cpu_valid || !cpu_lock)  state_next = ST_ATTN;
        else if (!done_reg)           state_next = ST_ADDR;
      end
      ST_ATTN:     state_next = ST_IDLE;
      default:     state_next = ST_IDLE;
    endcase

    if (state_reg == ST_ADDR)      cnt_next = '0;
    else if (state_reg == ST_DATA) cnt_next = cnt_reg + 8'd1;

    // Latch the attributes of the request as its address phase begins.
    if (state_next == ST_ADDR) begin
      lock_next  = cpu_lock;
      write_next = cpu_write;
    end

    if (ack_hit) begin
      done_next   = 1'b1;
      status_next = {~nub_tm1n, ~nub_tm0n};
      if (!write_reg) rdata_next = nub_ad_i;
    end else if (tmo_hit) begin
      done_next   = 1'b1;
      tmo_next    = 1'b1;
      status_next = 2'b11;
    end

    case (state_next)
      ST_ARB:      strobe_next = {1'b0, 3'b111, ~cpu_lock, 2'b11};
      ST_ADDR: begin
        strobe_next = {1'b0, 1'b0, 1'b1, 1'b0, ~lock_next, ~cpu_tm};
        ad_oe_next  = 1'b1;
        ad_o_next   = cpu_addr;
      end
      ST_DATA: begin
        // Locked sequences keep ARBCY asserted to hold the bus.
        strobe_next = {~lock_next, 1'b1, 1'b0, 1'b0, ~lock_next, 2'b11};
        if (write_next) begin
          ad_oe_next = 1'b1;
          ad_o_next  = cpu_wdata;
        end
      end
      ST_LOCKHOLD: strobe_next = 7'b011_0011;
      ST_ATTN:     strobe_next = 7'b011_0111;
      default:     strobe_next = STB_IDLE;
    endcase
  end

  assign {mst_arbcyn, mst_adrcyn, mst_dtacyn, mst_ownern,
          mst_lockedn, mst_tm1n, mst_tm0n} = strobe_reg;
  assign mst_timeout = tmo_reg;
  assign cpu_done    = done_reg;
  assign cpu_rdata   = rdata_reg;
  assign cpu_status  = status_reg;
  assign nub_ad_oe   = ad_oe_reg;
  assign nub_ad_o    = ad_o_reg;

endmodule

// File: tb/tb_nubus_master_fsm.sv
// Testbench for nubus_master_fsm. Expected per-clock outputs come from a
// phase-level description of each transaction (how many clocks of each bus
// phase, which strobes that phase asserts) built by the bench itself.
module tb_nubus_master_fsm;

  localparam int TMO = 8;

  // Strobe vectors {arbcyn, adrcyn, dtacyn, ownern, lockedn, tm1n, tm0n}
  localparam logic [6:0] S_IDLE     = 7'b111_1111;
  localparam logic [6:0] S_LOCKHOLD = 7'b011_0011;
  localparam logic [6:0] S_ATTN     = 7'b011_0111;

  logic        nub_clk;
  logic        nub_reset;
  logic        cpu_valid;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_write;
  logic [1:0]  cpu_tm;
  logic        cpu_lock;
  logic        cpu_done;
  logic [31:0] cpu_rdata;
  logic [1:0]  cpu_status;
  logic        arb_win;
  logic        nub_startn;
  logic        nub_ackn;
  logic        nub_tm1n;
  logic        nub_tm0n;
  logic [31:0] nub_ad_i;
  logic [31:0] nub_ad_o;
  logic        nub_ad_oe;
  logic        mst_arbcyn, mst_adrcyn, mst_dtacyn, mst_ownern;
  logic        mst_lockedn, mst_tm1n, mst_tm0n, mst_timeout;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_rdata;
  logic [1:0]  exp_status;

  nubus_master_fsm #(.TIMEOUT_CYCLES(TMO)) dut (
    .nub_clk(nub_clk), .nub_reset(nub_reset),
    .cpu_valid(cpu_valid), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_write(cpu_write), .cpu_tm(cpu_tm), .cpu_lock(cpu_lock),
    .cpu_done(cpu_done), .cpu_rdata(cpu_rdata), .cpu_status(cpu_status),
    .arb_win(arb_win), .nub_startn(nub_startn), .nub_ackn(nub_ackn),
    .nub_tm1n(nub_tm1n), .nub_tm0n(nub_tm0n), .nub_ad_i(nub_ad_i),
    .nub_ad_o(nub_ad_o), .nub_ad_oe(nub_ad_oe),
    .mst_arbcyn(mst_arbcyn), .mst_adrcyn(mst_adrcyn), .mst_dtacyn(mst_dtacyn),
    .mst_ownern(mst_ownern), .mst_lockedn(mst_lockedn), .mst_tm1n(mst_tm1n),
    .mst_tm0n(mst_tm0n), .mst_timeout(mst_timeout)
  );

  initial nub_clk = 1'b0;
  always #5 nub_clk = ~nub_clk;

  // Phase strobe descriptions
  function automatic logic [6:0] s_arb(input logic lk);
    return {1'b0, 3'b111, ~lk, 2'b11};
  endfunction
  function automatic logic [6:0] s_addr(input logic lk, input logic [1:0] tm);
    return {1'b0, 1'b0, 1'b1, 1'b0, ~lk, ~tm};
  endfunction
  function automatic logic [6:0] s_data(input logic lk);
    return {~lk, 1'b1, 1'b0, 1'b0, ~lk, 2'b11};
  endfunction

  // {strobes, timeout, done, oe, ad (only meaningful while driven)}
  function automatic logic [41:0] mk(input logic [6:0] s, input logic tmo, input logic done,
                                     input logic oe, input logic [31:0] ad);
    return {s, tmo, done, oe, (oe ? ad : 32'h0)};
  endfunction

  task automatic check_vec(input string tag, input logic [41:0] expv);
    logic [41:0] o;
    o = {mst_arbcyn, mst_adrcyn, mst_dtacyn, mst_ownern, mst_lockedn, mst_tm1n, mst_tm0n,
         mst_timeout, cpu_done, nub_ad_oe, (nub_ad_oe ? nub_ad_o : 32'h0)};
    n_tests++;
    assert (o === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, o, expv);
    end
  endtask

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic step(input string tag, input logic [41:0] expv);
    @(posedge nub_clk);
    #1;
    check_vec(tag, expv);
  endtask

  task automatic set_req(input logic wr, input logic lk, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [1:0] tm);
    cpu_valid = 1'b1;
    cpu_write = wr;
    cpu_lock  = lk;
    cpu_addr  = addr;
    cpu_wdata = wd;
    cpu_tm    = tm;
  endtask

  // Starts with the request on cpu_* and the DUT in ARB or LOCKHOLD and able
  // to move to ADDR. Returns after observing the completion clock.
  // ack_at > TMO means the slave never answers.
  task automatic run_txn(input string tag, input logic [31:0] rdv,
                         input logic [1:0] sts, input int ack_at);
    logic wr;
    logic lk;
    wr = cpu_write;
    lk = cpu_lock;
    arb_win = 1'b1;
    step({tag, "/addr"}, mk(s_addr(lk, cpu_tm), 1'b0, 1'b0, 1'b1, cpu_addr));
    arb_win = 1'b0;
    step({tag, "/data1"}, mk(s_data(lk), 1'b0, 1'b0, wr, cpu_wdata));
    for (int k = 1; k <= TMO; k++) begin
      nub_ackn = (k == ack_at) ? 1'b0 : 1'b1;
      nub_ad_i = (k == ack_at) ? rdv : $urandom;
      nub_tm1n = ~sts[1];
      nub_tm0n = ~sts[0];
      if (k == ack_at) begin
        step({tag, "/ackdone"}, mk(lk ? S_LOCKHOLD : S_IDLE, 1'b0, 1'b1, 1'b0, 32'h0));
        if (!wr) exp_rdata = rdv;
        exp_status = sts;
        break;
      end else if (k == TMO) begin
        step({tag, "/timeout"}, mk(lk ? S_ATTN : S_IDLE, 1'b1, 1'b1, 1'b0, 32'h0));
        exp_status = 2'b11;
      end else begin
        step({tag, "/data"}, mk(s_data(lk), 1'b0, 1'b0, wr, cpu_wdata));
      end
    end
    nub_ackn = 1'b1;
    nub_tm1n = 1'b1;
    nub_tm0n = 1'b1;
    check32({tag, "/rdata"}, cpu_rdata, exp_rdata);
    check32({tag, "/status"}, {30'h0, cpu_status}, {30'h0, exp_status});
    $display("[TB] txn %s wr=%0d lock=%0d addr=%h ack_at=%0d rdata=%h status=%0d",
             tag, wr, lk, cpu_addr, ack_at, cpu_rdata, cpu_status);
  endtask

  // Requester withdraws after completion; follow the bus back to IDLE.
  task automatic wind_down(input string tag, input logic lk, input logic timed_out);
    cpu_valid = 1'b0;
    if (lk && !timed_out)
      step({tag, "/attn"}, mk(S_ATTN, 1'b0, 1'b0, 1'b0, 32'h0));
    step({tag, "/idle"}, mk(S_IDLE, 1'b0, 1'b0, 1'b0, 32'h0));
  endtask

  initial begin
    nub_reset  = 1'b1;
    cpu_valid  = 1'b0;
    cpu_addr   = '0;
    cpu_wdata  = '0;
    cpu_write  = 1'b0;
    cpu_tm     = 2'b00;
    cpu_lock   = 1'b0;
    arb_win    = 1'b0;
    nub_startn = 1'b1;
    nub_ackn   = 1'b1;
    nub_tm1n   = 1'b1;
    nub_tm0n   = 1'b1;
    nub_ad_i   = '0;
    exp_rdata  = '0;
    exp_status = 2'b00;

    // Reset state
    step("reset", mk(S_IDLE, 1'b0, 1'b0, 1'b0, 32'h0));
    check32("reset/ad_o", nub_ad_o, 32'h0);
    check32("reset/rdata", cpu_rdata, 32'h0);
    check32("reset/status", {30'h0, cpu_status}, 32'h0);
    nub_reset = 1'b0;
    step("idle0", mk(S_IDLE, 1'b0, 1'b0, 1'b0, 32'h0));

    // Unlocked write, ACK on the 3rd DATA clock, one ARB clock
    set_req(1'b1, 1'b0, 32'hF000_1000, 32'hDEAD_BEEF, 2'b01);
    step("wr/arb", mk(s_arb(1'b0), 1'b0, 1'b0, 1'b0, 32'h0));
    run_txn("wr", 32'h0, 2'b00, 3);
    wind_down("wr", 1'b0, 1'b0);

    // Unlocked read, slave status 00
    set_req(1'b0, 1'b0, 32'h0000_0040, 32'h0, 2'b00);
    step("rd/arb", mk(s_arb(1'b0), 1'b0, 1'b0, 1'b0, 32'h0));
    run_txn("rd", 32'h1234_5678, 2'b00, 1);
    wind_down("rd", 1'b0, 1'b0);

    // Foreign START seen while arbitrating: hold off until its ACK
    set_req(1'b0, 1'b0, 32'hA5A5_0000, 32'h0, 2'b10);
    arb_win    = 1'b1;
    nub_startn = 1'b0;
    step("busy/arb0", mk(s_arb(1'b0), 1'b0, 1'b0, 1'b0, 32'h0));
    nub_startn = 1'b1;
    step("busy/arb1", mk(s_arb(1'b0), 1'b0, 1'b0, 1'b0, 32'h0));
    step("busy/arb2", mk(s_arb(1'b0), 1'b0, 1'b0, 1'b0, 32'h0));
    nub_ackn = 1'b0;
    step("busy/arb3", mk(s_arb(1'b0), 1'b0, 1'b0, 1'b0, 32'h0));
    nub_ackn = 1'b1;
    run_txn("busy", 32'h0BAD_CAFE, 2'b01, 2);
    wind_down("busy", 1'b0, 1'b0);

    // No ACK: timeout on the 8th DATA clock
    set_req(1'b1, 1'b0, 32'h1111_2222, 32'h3333_4444, 2'b11);
    step("tmo/arb", mk(s_arb(1'b0), 1'b0, 1'b0, 1'b0, 32'h0));
    run_txn("tmo", 32'h0, 2'b00, TMO + 1);
    wind_down("tmo", 1'b0, 1'b1);

    // ACK on the very clock the timeout would fire
    set_req(1'b0, 1'b0, 32'h5555_6666, 32'h0, 2'b00);
    step("acktmo/arb", mk(s_arb(1'b0), 1'b0, 1'b0, 1'b0, 32'h0));
    run_txn("acktmo", 32'h7777_8888, 2'b10, TMO);
    wind_down("acktmo", 1'b0, 1'b0);

    // Locked read then locked write; second skips arbitration
    set_req(1'b0, 1'b1, 32'hC000_0000, 32'h0, 2'b01);
    step("lk1/arb", mk(s_arb(1'b1), 1'b0, 1'b0, 1'b0, 32'h0));
    run_txn("lk1", 32'h9ABC_DEF0, 2'b00, 2);
    set_req(1'b1, 1'b1, 32'hC000_0004, 32'h0F0F_0F0F, 2'b10);
    step("lk2/hold", mk(S_LOCKHOLD, 1'b0, 1'b0, 1'b0, 32'h0));
    run_txn("lk2", 32'h0, 2'b01, 4);
    wind_down("lk2", 1'b1, 1'b0);

    // Reset in the middle of DATA
    set_req(1'b1, 1'b0, 32'h2468_ACE0, 32'h1357_9BDF, 2'b00);
    step("rst/arb", mk(s_arb(1'b0), 1'b0, 1'b0, 1'b0, 32'h0));
    arb_win = 1'b1;
    step("rst/addr", mk(s_addr(1'b0, 2'b00), 1'b0, 1'b0, 1'b1, 32'h2468_ACE0));
    arb_win = 1'b0;
    step("rst/data1", mk(s_data(1'b0), 1'b0, 1'b0, 1'b1, 32'h1357_9BDF));
    step("rst/data2", mk(s_data(1'b0), 1'b0, 1'b0, 1'b1, 32'h1357_9BDF));
    nub_reset = 1'b1;
    step("rst/abort", mk(S_IDLE, 1'b0, 1'b0, 1'b0, 32'h0));
    exp_rdata  = '0;
    exp_status = 2'b00;
    check32("rst/rdata", cpu_rdata, exp_rdata);
    check32("rst/status", {30'h0, cpu_status}, {30'h0, exp_status});
    nub_reset = 1'b0;
    step("rst/rearb", mk(s_arb(1'b0), 1'b0, 1'b0, 1'b0, 32'h0));
    run_txn("rst", 32'h0, 2'b11, 1);
    wind_down("rst", 1'b0, 1'b0);

    // Randomised transactions
    for (int t = 0; t < 16; t++) begin
      logic        wr, lk;
      logic [31:0] addr, wd, rdv;
      logic [1:0]  tm, sts;
      int          aw, ack_at;
      string       tag;
      wr     = 1'($urandom_range(0, 1));
      lk     = 1'($urandom_range(0, 1));
      addr   = $urandom;
      wd     = $urandom;
      rdv    = $urandom;
      tm     = 2'($urandom_range(0, 3));
      sts    = 2'($urandom_range(0, 3));
      aw     = $urandom_range(0, 3);
      ack_at = $urandom_range(1, TMO + 1);
      tag    = $sformatf("rnd%0d", t);
      set_req(wr, lk, addr, wd, tm);
      step({tag, "/arb"}, mk(s_arb(lk), 1'b0, 1'b0, 1'b0, 32'h0));
      for (int i = 0; i < aw; i++)
        step({tag, "/arbwait"}, mk(s_arb(lk), 1'b0, 1'b0, 1'b0, 32'h0));
      run_txn(tag, rdv, sts, ack_at);
      wind_down(tag, lk, ack_at > TMO);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/nubus_master_fsm.md
Name: nubus_master_fsm

Overview:
- Sequential NuBus master state machine sitting directly upstream of the bus driver.
- Accepts one transaction request at a time from the card-side requester.
- Sequences arbitration, address, data and attention phases, and produces the active-low phase strobes (mst_arbcyn, mst_adrcyn, mst_dtacyn, mst_ownern, mst_lockedn, mst_tm1n/mst_tm0n, mst_timeout) that the driver decodes.
- Also steers AD for the address and write-data phases, and returns read data and status.

Parameters:
- TIMEOUT_CYCLES, 255: clocks waited in DATA for ACK before a forced timeout. Legal range 2..255.

Ports:
- nub_clk  in  1  NuBus clock; all state changes on the rising edge.
- nub_reset  in  1  synchronous, active-high reset.
- cpu_valid  in  1  request present; held stable until cpu_done.
- cpu_addr  in  32  transaction address.
- cpu_wdata  in  32  write data.
- cpu_write  in  1  1 = write, 0 = read.
- cpu_tm  in  2  address-cycle transfer mode, passed through as given.
- cpu_lock  in  1  1 = this request belongs to a locked sequence.
- cpu_done  out  1  one-clock pulse when the request completes (ACK or timeout).
- cpu_rdata  out  32  read data captured at ACK.
- cpu_status  out  2  slave response {~nub_tm1n, ~nub_tm0n} captured at ACK; 2'b11 on timeout.
- arb_win  in  1  arbitration comparator result, valid in the ARB state.
- nub_startn  in  1  sampled NuBus START*.
- nub_ackn  in  1  sampled NuBus ACK*.
- nub_ad_i  in  32  sampled AD bus.
- nub_ad_o  out  32  AD value to drive.
- nub_ad_oe  out  1  AD output enable.
- mst_arbcyn, mst_adrcyn, mst_dtacyn, mst_ownern, mst_lockedn, mst_tm1n, mst_tm0n  out  1 each  phase strobes to the driver.
- mst_timeout  out  1  one-clock timeout pulse to the driver.

Behaviour:
- Reset (synchronous):
  - State IDLE.
  - All mst_*n = 1, mst_timeout = 0, cpu_done = 0, cpu_rdata = 0, cpu_status = 0, nub_ad_oe = 0, nub_ad_o = 0.
  - busy tracker cleared; timeout counter = 0.
  - Reset mid-transaction abandons it immediately; no cpu_done is issued.
- Busy tracker (bus_busy):
  - Set when nub_startn = 0 and nub_ackn = 1 while this block is not the owner.
  - Cleared when nub_ackn = 0.
  - START and ACK together (attention cycle) leave it unchanged.
- IDLE:
  - All strobes deasserted.
  - cpu_valid = 1 -> ARB; mst_lockedn follows ~cpu_lock from ARB onward.
- ARB:
  - mst_arbcyn = 0.
  - When arb_win = 1 and bus_busy = 0 and nub_startn = 1 -> ADDR. Otherwise stay; no timeout applies in ARB.
- ADDR (exactly 1 clock):
  - mst_ownern = 0, mst_arbcyn = 0, mst_adrcyn = 0, mst_dtacyn = 1.
  - mst_tm1n/mst_tm0n = ~cpu_tm.
  - nub_ad_oe = 1, nub_ad_o = cpu_addr.
  - Next state DATA; timeout counter loaded to 0.
- DATA:
  - mst_ownern = 0, mst_dtacyn = 0, mst_adrcyn = 1, mst_tm*n = 1.
  - mst_arbcyn = 0 only if locked, else 1.
  - Write: nub_ad_oe = 1, nub_ad_o = cpu_wdata. Read: nub_ad_oe = 0.
  - Counter increments each clock.
  - nub_ackn = 0:
    - Capture cpu_rdata = nub_ad_i (reads only) and cpu_status.
    - Pulse cpu_done.
    - Next state LOCKHOLD if locked, else IDLE.
  - Counter reaches TIMEOUT_CYCLES-1 with no ACK:
    - mst_timeout = 1 for one clock; cpu_status = 2'b11; cpu_done pulses.
    - Next state is ATTN if locked, else IDLE.
  - ACK in the same clock as the timeout: the ACK wins.
- LOCKHOLD:
  - mst_ownern = 0, mst_arbcyn = 0, mst_lockedn = 0, mst_adrcyn = 1, mst_dtacyn = 1.
  - nub_ad_oe = 0.
  - Any cpu_valid must be a new request, not one already acknowledged with cpu_done.
  - New cpu_valid with cpu_lock = 1 -> ADDR directly, skipping arbitration.
  - cpu_valid with cpu_lock = 0, or no request pending -> ATTN on the next clock in which cpu_valid = 0 or cpu_lock = 0.
- ATTN (exactly 1 clock):
  - mst_ownern = 0, mst_arbcyn = 0, mst_lockedn = 1, mst_adrcyn = 1, mst_dtacyn = 1. The driver turns this into the NULL-ATTN cycle.
  - Next state IDLE. A pending unlocked request then re-arbitrates from IDLE.
- General rules:
  - All outputs are registered.
  - Strobes change only on state transitions.
  - cpu_rdata and cpu_status hold their values until the next capture.

Test Plan:
- Unlocked write with arb_win = 1, bus idle, cpu_addr = 0xF0001000, wdata = 0xDEADBEEF, ACK on the 3rd DATA clock -> ARB 1 clk, ADDR drives 0xF0001000, DATA drives 0xDEADBEEF, single cpu_done pulse, return to IDLE, mst_lockedn stays 1 throughout.
- Read with ACK, nub_ad_i = 0x12345678, tm = 00 -> cpu_rdata = 0x12345678, cpu_status = 0, nub_ad_oe = 0 in DATA.
- Foreign START without ACK while in ARB with arb_win = 1 -> remain in ARB until the foreign ACK clears bus_busy, then ADDR on the following clock.
- No ACK, TIMEOUT_CYCLES = 8 -> mst_timeout pulses exactly on the 8th DATA clock, cpu_status = 11, cpu_done pulses, IDLE; a second case where ACK coincides with the timeout clock -> ACK data captured and no mst_timeout pulse.
- Locked pair: read then write, both with cpu_lock = 1, then cpu_valid drops -> second ADDR follows LOCKHOLD with no ARB; mst_lockedn = 0 until ATTN; ATTN lasts 1 clk with mst_arbcyn = 0 and mst_adrcyn = mst_dtacyn = 1; then IDLE.
- nub_reset asserted during DATA -> next clock all strobes = 1, nub_ad_oe = 0, no cpu_done; a fresh request then starts from ARB.
